// File: rtl/id_stage_pkg.sv
// Shared RV32I decode constants, decode-control struct and the base-ISA opcode decoder
// used by the registered instruction-decode stage.
package id_stage_pkg;

   localparam int XLEN_DEF = 32;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_FENCE  = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_LHU  = 3'b101;
   localparam logic [2:0] F3_SW   = 3'b010;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef enum logic [1:0] {A_ZERO, A_RS1, A_IMM_U, A_IMM_J} op1_sel_e;
   typedef enum logic [2:0] {B_ZERO, B_RS2, B_IMM_I, B_IMM_S, B_SHAMT, B_PC} op2_sel_e;
   typedef enum logic [1:0] {V_ZERO, V_RS2, V_IMM_B} rs2v_sel_e;

   typedef struct packed {
      op1_sel_e  op1_sel;
      op2_sel_e  op2_sel;
      rs2v_sel_e rs2v_sel;
      logic      use_rs1;
      logic      use_rs2;
      logic      use_rd;
      logic      illegal;
   } dec_t;

   // A register field is out of range when any bit above the implemented width is set.
   function automatic logic reg_oob(input logic [4:0] idx, input int aw);
      return (aw < 5) && ((idx >> aw) != 5'd0);
   endfunction

   function automatic dec_t decode(input logic [31:0] inst);
      dec_t       d;
      logic [2:0] f3;
      logic [6:0] f7;
      f3 = inst[14:12];
      f7 = inst[31:25];
      d.op1_sel  = A_ZERO;
      d.op2_sel  = B_ZERO;
      d.rs2v_sel = V_ZERO;
      d.use_rs1  = 1'b0;
      d.use_rs2  = 1'b0;
      d.use_rd   = 1'b0;
      d.illegal  = 1'b0;
      case (inst[6:0])
         OPC_LUI: begin
            d.op1_sel = A_IMM_U;
            d.use_rd  = 1'b1;
         end
         OPC_AUIPC: begin
            d.op1_sel = A_IMM_U;
            d.op2_sel = B_PC;
            d.use_rd  = 1'b1;
         end
         OPC_JAL: begin
            d.op1_sel = A_IMM_J;
            d.use_rd  = 1'b1;
         end
         OPC_JALR: begin
            d.op1_sel = A_RS1;
            d.op2_sel = B_IMM_I;
            d.use_rs1 = 1'b1;
            d.use_rd  = 1'b1;
            d.illegal = (f3 != F3_ADD);
         end
         OPC_BRANCH: begin
            d.op1_sel  = A_RS1;
            d.op2_sel  = B_RS2;
            d.rs2v_sel = V_IMM_B;
            d.use_rs1  = 1'b1;
            d.use_rs2  = 1'b1;
            d.illegal  = (f3 == F3_SLT) || (f3 == F3_SLTU);
         end
         OPC_LOAD: begin
            d.op1_sel = A_RS1;
            d.op2_sel = B_IMM_I;
            d.use_rs1 = 1'b1;
            d.use_rd  = 1'b1;
            d.illegal = (f3 == F3_SLTU) || (f3 > F3_LHU);
         end
         OPC_STORE: begin
            d.op1_sel  = A_RS1;
            d.op2_sel  = B_IMM_S;
            d.rs2v_sel = V_RS2;
            d.use_rs1  = 1'b1;
            d.use_rs2  = 1'b1;
            d.illegal  = (f3 > F3_SW);
         end
         OPC_OP_IMM: begin
            d.op1_sel = A_RS1;
            d.op2_sel = B_IMM_I;
            d.use_rs1 = 1'b1;
            d.use_rd  = 1'b1;
            if (f3 == F3_SLL) begin
               d.op2_sel = B_SHAMT;
               d.illegal = (f7 != F7_BASE);
            end else if (f3 == F3_SR) begin
               d.op2_sel = B_SHAMT;
               d.illegal = (f7 != F7_BASE) && (f7 != F7_ALT);
            end
         end
         OPC_OP: begin
            d.op1_sel = A_RS1;
            d.op2_sel = B_RS2;
            d.use_rs1 = 1'b1;
            d.use_rs2 = 1'b1;
            d.use_rd  = 1'b1;
            d.illegal = !((f7 == F7_BASE) || ((f7 == F7_ALT) && ((f3 == F3_ADD) || (f3 == F3_SR))));
         end
         OPC_FENCE:  d.illegal = (f3 != F3_ADD);
         // Only ECALL and EBREAK; CSR access belongs to Zicsr.
         OPC_SYSTEM: d.illegal = (inst[31:7] != 25'h0) && (inst[31:7] != 25'h2000);
         default:    d.illegal = 1'b1;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/id_fwd_mux.sv
// Source-operand selection: EX result (non-load) over MEM result over regfile; x0 reads 0.
module id_fwd_mux import id_stage_pkg::*; #(
   parameter int XLEN       = XLEN_DEF,
   parameter int REG_ADDR_W = 5,
   parameter bit EN_FWD     = 1'b1
) (
   input  logic [REG_ADDR_W-1:0] rs_addr_i,
   input  logic [XLEN-1:0]       rf_data_i,
   input  logic                  ex_wen_i,
   input  logic                  ex_is_load_i,
   input  logic [REG_ADDR_W-1:0] ex_rd_i,
   input  logic [XLEN-1:0]       ex_data_i,
   input  logic                  mem_wen_i,
   input  logic [REG_ADDR_W-1:0] mem_rd_i,
   input  logic [XLEN-1:0]       mem_data_i,
   output logic [XLEN-1:0]       data_o
);

   always_comb begin
      data_o = rf_data_i;
      if (rs_addr_i == '0)
         data_o = '0;
      else if (EN_FWD && ex_wen_i && !ex_is_load_i && (ex_rd_i == rs_addr_i))
         data_o = ex_data_i;
      else if (EN_FWD && mem_wen_i && (mem_rd_i == rs_addr_i))
         data_o = mem_data_i;
   end

endmodule

// File: rtl/id_stage.sv
// Registered RV32I/RV32E decode stage: regfile read, EX/MEM forwarding, load-use stall,
// and a valid/ready output register with local back-pressure and flush handling.
module id_stage import id_stage_pkg::*; #(
   parameter int XLEN       = XLEN_DEF,
   parameter int REG_ADDR_W = 5,
   parameter bit EN_FWD     = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [31:0]           inst_i,
   input  logic [XLEN-1:0]       inst_addr_i,
   output logic [REG_ADDR_W-1:0] rs1_addr_o,
   output logic [REG_ADDR_W-1:0] rs2_addr_o,
   input  logic [XLEN-1:0]       rs1_data_i,
   input  logic [XLEN-1:0]       rs2_data_i,
   input  logic                  ex_wen_i,
   input  logic                  ex_is_load_i,
   input  logic [REG_ADDR_W-1:0] ex_rd_i,
   input  logic [XLEN-1:0]       ex_data_i,
   input  logic                  mem_wen_i,
   input  logic [REG_ADDR_W-1:0] mem_rd_i,
   input  logic [XLEN-1:0]       mem_data_i,
   input  logic                  flush_i,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [31:0]           inst_o,
   output logic [XLEN-1:0]       inst_addr_o,
   output logic [XLEN-1:0]       op1_o,
   output logic [XLEN-1:0]       op2_o,
   output logic [XLEN-1:0]       rs2_val_o,
   output logic [REG_ADDR_W-1:0] rd_addr_o,
   output logic                  reg_wen_o,
   output logic                  illegal_o
);

   logic [4:0]      rs1_idx, rs2_idx, rd_idx;
   dec_t            dec;
   logic            illegal, stall, accept;
   logic [XLEN-1:0] rs1_val, rs2_val, op1_n, op2_n, rs2v_n;
   logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j, imm_u;

   logic                  valid_q, valid_d;
   logic [31:0]           inst_q, inst_d;
   logic [XLEN-1:0]       pc_q, pc_d, op1_q, op1_d, op2_q, op2_d, rs2v_q, rs2v_d;
   logic [REG_ADDR_W-1:0] rd_q, rd_d;
   logic                  wen_q, wen_d, ill_q, ill_d;

   assign rs1_idx    = inst_i[19:15];
   assign rs2_idx    = inst_i[24:20];
   assign rd_idx     = inst_i[11:7];
   assign rs1_addr_o = rs1_idx[REG_ADDR_W-1:0];
   assign rs2_addr_o = rs2_idx[REG_ADDR_W-1:0];

   assign dec     = decode(inst_i);
   assign illegal = dec.illegal
                 || (dec.use_rs1 && reg_oob(rs1_idx, REG_ADDR_W))
                 || (dec.use_rs2 && reg_oob(rs2_idx, REG_ADDR_W))
                 || (dec.use_rd  && reg_oob(rd_idx,  REG_ADDR_W));

   // Load data only exists from MEM onward, so a dependent instruction waits one cycle.
   assign stall = ex_is_load_i && ex_wen_i && (ex_rd_i != '0) && !illegal
               && ((dec.use_rs1 && (rs1_addr_o == ex_rd_i)) || (dec.use_rs2 && (rs2_addr_o == ex_rd_i)));

   assign in_ready = flush_i || (!stall && (!valid_q || out_ready));
   assign accept   = in_valid && in_ready && !flush_i;

   id_fwd_mux #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W), .EN_FWD(EN_FWD)) u_fwd_rs1 (
      .rs_addr_i(rs1_addr_o), .rf_data_i(rs1_data_i),
      .ex_wen_i(ex_wen_i), .ex_is_load_i(ex_is_load_i), .ex_rd_i(ex_rd_i), .ex_data_i(ex_data_i),
      .mem_wen_i(mem_wen_i), .mem_rd_i(mem_rd_i), .mem_data_i(mem_data_i),
      .data_o(rs1_val)
   );

   id_fwd_mux #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W), .EN_FWD(EN_FWD)) u_fwd_rs2 (
      .rs_addr_i(rs2_addr_o), .rf_data_i(rs2_data_i),
      .ex_wen_i(ex_wen_i), .ex_is_load_i(ex_is_load_i), .ex_rd_i(ex_rd_i), .ex_data_i(ex_data_i),
      .mem_wen_i(mem_wen_i), .mem_rd_i(mem_rd_i), .mem_data_i(mem_data_i),
      .data_o(rs2_val)
   );

   assign imm_i = XLEN'($signed(inst_i[31:20]));
   assign imm_s = XLEN'($signed({inst_i[31:25], inst_i[11:7]}));
   assign imm_b = XLEN'($signed({inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0}));
   assign imm_j = XLEN'($signed({inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0}));
   assign imm_u = XLEN'($signed({inst_i[31:12], 12'b0}));

   always_comb begin
      op1_n  = '0;
      op2_n  = '0;
      rs2v_n = '0;
      case (dec.op1_sel)
         A_RS1:   op1_n = rs1_val;
         A_IMM_U: op1_n = imm_u;
         A_IMM_J: op1_n = imm_j;
         default: op1_n = '0;
      endcase
      case (dec.op2_sel)
         B_RS2:   op2_n = rs2_val;
         B_IMM_I: op2_n = imm_i;
         B_IMM_S: op2_n = imm_s;
         B_SHAMT: op2_n = XLEN'(inst_i[24:20]);
         B_PC:    op2_n = inst_addr_i;
         default: op2_n = '0;
      endcase
      case (dec.rs2v_sel)
         V_RS2:   rs2v_n = rs2_val;
         V_IMM_B: rs2v_n = imm_b;
         default: rs2v_n = '0;
      endcase
      if (illegal) begin
         op1_n  = '0;
         op2_n  = '0;
         rs2v_n = '0;
      end
   end

   always_comb begin
      valid_d = valid_q;
      inst_d  = inst_q;
      pc_d    = pc_q;
      op1_d   = op1_q;
      op2_d   = op2_q;
      rs2v_d  = rs2v_q;
      rd_d    = rd_q;
      wen_d   = wen_q;
      ill_d   = ill_q;
      if (flush_i) begin
         valid_d = 1'b0;
      end else if (accept) begin
         valid_d = 1'b1;
         inst_d  = inst_i;
         pc_d    = inst_addr_i;
         op1_d   = op1_n;
         op2_d   = op2_n;
         rs2v_d  = rs2v_n;
         rd_d    = dec.use_rd ? rd_idx[REG_ADDR_W-1:0] : '0;
         wen_d   = dec.use_rd && (rd_idx != 5'd0) && !illegal;
         ill_d   = illegal;
      end else if (!valid_q || out_ready) begin
         // Drained or stalled with a free slot: issue a bubble.
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         inst_q  <= '0;
         pc_q    <= '0;
         op1_q   <= '0;
         op2_q   <= '0;
         rs2v_q  <= '0;
         rd_q    <= '0;
         wen_q   <= 1'b0;
         ill_q   <= 1'b0;
      end else begin
         valid_q <= valid_d;
         inst_q  <= inst_d;
         pc_q    <= pc_d;
         op1_q   <= op1_d;
         op2_q   <= op2_d;
         rs2v_q  <= rs2v_d;
         rd_q    <= rd_d;
         wen_q   <= wen_d;
         ill_q   <= ill_d;
      end
   end

   assign out_valid   = valid_q;
   assign inst_o      = inst_q;
   assign inst_addr_o = pc_q;
   assign op1_o       = op1_q;
   assign op2_o       = op2_q;
   assign rs2_val_o   = rs2v_q;
   assign rd_addr_o   = rd_q;
   assign reg_wen_o   = wen_q;
   assign illegal_o   = ill_q;

endmodule
